// File: rtl/crop_row.sv
// rtl/crop_row.sv - drops N padding rows above/below a padded frame; optional checks via CROP_ROW_CHECK_EN
module crop_row #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int DEPTH      = 504,
    parameter int N          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  data_en_in,
    input  logic [DATA_WIDTH-1:0] fmap_in,
    output logic [DATA_WIDTH-1:0] fmap_out,
    output logic                  data_en_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy
`ifdef CROP_ROW_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int ROWS = DEPTH + 2 * N;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_TOP_LAST  = RW'(N - 1);
    localparam logic [RW-1:0] ROW_FIRST     = RW'(N);
    localparam logic [RW-1:0] ROW_PASS_LAST = RW'(N + DEPTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, TOP, PASS, BOT, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] col, col_next;
    logic [RW-1:0] row, row_next;
    logic          fwd;
    logic          abort;
    logic          col_wrap;

    assign col_wrap = data_en_in && (col == COL_LAST);

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        fwd        = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                col_next = '0;
                row_next = '0;
                if (start_in) state_next = (N == 0) ? PASS : TOP;
            end
            TOP, PASS, BOT: begin
                fwd = (state == PASS) && data_en_in;
                if (data_en_in) begin
                    col_next = col_wrap ? '0 : col + 1'b1;
                    if (col_wrap) row_next = (row == ROW_LAST) ? '0 : row + 1'b1;
                end
                // Abort wins over any row-boundary transition on the same beat
                if (!start_in) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                    col_next   = '0;
                    row_next   = '0;
                end else if (col_wrap) begin
                    if (state == TOP && row == ROW_TOP_LAST)
                        state_next = PASS;
                    else if (state == PASS && row == ROW_PASS_LAST)
                        state_next = (N == 0) ? DONE : BOT;
                    else if (state == BOT && row == ROW_LAST)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (!start_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            fmap_out    <= '0;
            data_en_out <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            fmap_out    <= fwd ? fmap_in : '0;
            data_en_out <= fwd;
            sof         <= fwd && (row == ROW_FIRST) && (col == '0);
            eol         <= fwd && (col == COL_LAST);
            eof         <= fwd && start_in && (row == ROW_PASS_LAST) && (col == COL_LAST);
            busy        <= (state_next != IDLE);
        end
    end

`ifdef CROP_ROW_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (abort || (data_en_in && (state == IDLE || state == DONE)))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_crop_row.sv
// tb/tb_crop_row.sv - table vectors plus randomized frames against a pixel-index model of crop_row
`timescale 1ns/1ps
module tb_crop_row;

    localparam int W    = 4;
    localparam int D    = 3;
    localparam int NP   = 1;
    localparam int ROWS = D + 2 * NP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        data_en_in = 1'b0;
    logic [15:0] fmap_in = '0;
    logic [15:0] fmap_out;
    logic        data_en_out, sof, eol, eof, busy;
`ifdef CROP_ROW_CHECK_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    crop_row #(.DATA_WIDTH(16), .WIDTH(W), .DEPTH(D), .N(NP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_in    (start_in),
        .data_en_in  (data_en_in),
        .fmap_in     (fmap_in),
        .fmap_out    (fmap_out),
        .data_en_out (data_en_out),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .busy        (busy)
`ifdef CROP_ROW_CHECK_EN
        ,
        .err         (err)
`endif
    );

    typedef struct {
        logic s, d; logic [15:0] x;
        logic en; logic [15:0] q; logic so, eo, ef, bz;
    } vec_t;
    vec_t tbl[$];

    int vectors = 0;
    int miscompares = 0;

    // Model: pixel index k since frame start decides everything
    int          mode = 0;
    int          k = 0;
    logic        e_en, e_so, e_eo, e_ef, e_bz;
    logic [15:0] e_q;
    logic        err_m = 1'b0;

    task automatic tv(input logic s, d, input int x, input logic en, input int q,
                      input logic so, eo, ef, bz);
        vec_t v;
        v.s = s; v.d = d; v.x = 16'(x); v.en = en; v.q = 16'(q);
        v.so = so; v.eo = eo; v.ef = ef; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic model(input logic s, d, input logic [15:0] x);
        int r, c;
        e_en = 0; e_q = 0; e_so = 0; e_eo = 0; e_ef = 0;
        case (mode)
            0: begin
                if (d) err_m = 1'b1;
                if (s) begin mode = 1; k = 0; end
            end
            1: begin
                if (d) begin
                    r = k / W; c = k % W;
                    if (r >= NP && r < NP + D) begin
                        e_en = 1; e_q = x;
                        e_so = (k == NP * W);
                        e_eo = (c == W - 1);
                        e_ef = (k == (NP + D) * W - 1) && s;
                    end
                    k++;
                end
                if (!s) begin mode = 0; err_m = 1'b1; end
                else if (k == ROWS * W) mode = 2;
            end
            default: begin
                if (d) err_m = 1'b1;
                if (!s) mode = 0;
            end
        endcase
        e_bz = (mode != 0);
    endtask

    task automatic check(input string name, input logic en, input logic [15:0] q,
                         input logic so, eo, ef, bz);
        logic bad;
        vectors++;
        bad = (data_en_out !== en) || (fmap_out !== q) || (sof !== so) ||
              (eol !== eo) || (eof !== ef) || (busy !== bz);
`ifdef CROP_ROW_CHECK_EN
        bad = bad || (err !== err_m);
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got en=%b q=%0d sof=%b eol=%b eof=%b busy=%b, expected en=%b q=%0d sof=%b eol=%b eof=%b busy=%b",
                     name, $time, data_en_out, fmap_out, sof, eol, eof, busy, en, q, so, eo, ef, bz);
        end
    endtask

    task automatic drive_edge(input logic s, d, input logic [15:0] x);
        start_in = s; data_en_in = d; fmap_in = x;
        @(posedge clk);
        model(s, d, x);
        @(negedge clk);
    endtask

    task automatic step(input logic s, d, input logic [15:0] x);
        drive_edge(s, d, x);
        check("model", e_en, e_q, e_so, e_eo, e_ef, e_bz);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            drive_edge(tbl[i].s, tbl[i].d, tbl[i].x);
            check("table", tbl[i].en, tbl[i].q, tbl[i].so, tbl[i].eo, tbl[i].ef, tbl[i].bz);
        end
    endtask

    // Frame of ROWS*W pixels; start_in drops on pixel abort_at (if in range)
    task automatic run_frame(input int minb, input int maxb, input bit rnd, input int abort_at);
        logic s;
        step(1, 0, 16'($urandom));
        for (int p = 0; p < ROWS * W; p++) begin
            if (rnd && $urandom_range(3, 0) == 0) step(1, 0, 16'($urandom));
            s = (p != abort_at);
            step(s, 1, rnd ? 16'($urandom) : 16'(10 * (p / W) + p % W));
            if (!s) return;
            if (p % W == W - 1)
                for (int b = 0; b < int'($urandom_range(maxb, minb)); b++) step(1, 0, 16'($urandom));
        end
    endtask

    task automatic reset_check(input string name);
        check(name, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tv(1,0,0, 0,0,0,0,0,1);
        tv(1,1,5, 0,0,0,0,0,1); tv(1,1,6, 0,0,0,0,0,1); tv(1,1,7, 0,0,0,0,0,1); tv(1,1,8, 0,0,0,0,0,1);
        tv(1,0,0, 0,0,0,0,0,1); tv(1,0,0, 0,0,0,0,0,1);
        tv(1,1,10, 1,10,1,0,0,1); tv(1,1,11, 1,11,0,0,0,1); tv(1,1,12, 1,12,0,0,0,1); tv(1,1,13, 1,13,0,1,0,1);
        tv(1,0,0, 0,0,0,0,0,1); tv(1,0,0, 0,0,0,0,0,1);
        tv(1,1,20, 1,20,0,0,0,1); tv(1,1,21, 1,21,0,0,0,1); tv(1,1,22, 1,22,0,0,0,1); tv(1,1,23, 1,23,0,1,0,1);
        tv(1,0,0, 0,0,0,0,0,1); tv(1,0,0, 0,0,0,0,0,1);
        tv(1,1,30, 1,30,0,0,0,1); tv(1,1,31, 1,31,0,0,0,1); tv(1,1,32, 1,32,0,0,0,1); tv(1,1,33, 1,33,0,1,1,1);
        tv(1,0,0, 0,0,0,0,0,1); tv(1,0,0, 0,0,0,0,0,1);
        tv(1,1,40, 0,0,0,0,0,1); tv(1,1,41, 0,0,0,0,0,1); tv(1,1,42, 0,0,0,0,0,1); tv(1,1,43, 0,0,0,0,0,1);
        tv(1,0,0, 0,0,0,0,0,1); tv(1,0,0, 0,0,0,0,0,1);
        tv(0,0,0, 0,0,0,0,0,0);

        // Reset state
        repeat (2) begin @(negedge clk); reset_check("reset"); end
        rst_n = 1'b1;
        step(0, 0, 0);

        // Full frame, padding rows non-zero
        run_table();

        // Abort on pixel 21 (row 2, col 1)
        run_frame(2, 2, 0, 2 * W + 1);
        vectors++;
        if (data_en_out !== 1'b1 || fmap_out !== 16'd21 || eof !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_end: got en=%b q=%0d eof=%b busy=%b, expected en=1 q=21 eof=0 busy=0",
                     data_en_out, fmap_out, eof, busy);
        end
`ifdef CROP_ROW_CHECK_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_err: got err=%b, expected 1", err);
        end
`endif
        step(0, 0, 0);

        // Reset in the middle of PASS, then a fresh frame
        step(1, 0, 0);
        for (int p = 0; p < W + 2; p++) step(1, 1, 16'(100 + p));
        #2 rst_n = 1'b0;
        #1 reset_check("reset_mid_pass");
        mode = 0; err_m = 1'b0;
        repeat (2) begin @(negedge clk); reset_check("reset_hold"); end
        rst_n = 1'b1;
        step(0, 0, 0);
        run_table();

        // data_en_in pulse while in DONE
        run_frame(2, 2, 0, -1);
        step(1, 1, 16'hBEEF);
        vectors++;
        if (data_en_out !== 1'b0 || fmap_out !== 16'd0) begin
            miscompares++;
            $display("FAIL done_pulse: got en=%b q=%0d, expected en=0 q=0", data_en_out, fmap_out);
        end
`ifdef CROP_ROW_CHECK_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL done_err: got err=%b, expected 1", err);
        end
`endif
        step(0, 0, 0);
        @(negedge clk) rst_n = 1'b0;
        mode = 0; err_m = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back frames, one low cycle between
        run_frame(2, 2, 0, -1);
        step(0, 0, 0);
        run_frame(0, 3, 1, -1);
        step(0, 0, 0);

        // Randomized frames with random blanking, gaps, aborts and idle noise
        for (int f = 0; f < 25; f++) begin
            run_frame(0, 3, 1, ($urandom_range(3, 0) == 0) ? int'($urandom_range(ROWS * W - 1, 0)) : -1);
            for (int g = 0; g < int'($urandom_range(3, 1)); g++)
                step(0, ($urandom_range(7, 0) == 0), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crop_row.md
CROP_ROW -- requirements
Module: crop_row

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel word width.
REQ-002 Parameter WIDTH, default 640, valid pixels per row.
REQ-003 Parameter DEPTH, default 504, unpadded rows per frame.
REQ-004 Parameter N, default 4, zero-padding rows above and below the frame (padded frame = DEPTH+2N rows).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_in  input  1  padded-frame window, high for the whole padded frame.
REQ-008 data_en_in  input  1  pixel valid on fmap_in; blanking cycles between rows carry data_en_in=0.
REQ-009 fmap_in  input  DATA_WIDTH  padded pixel stream.
REQ-010 fmap_out  output  DATA_WIDTH  cropped pixel, zero when data_en_out=0.
REQ-011 data_en_out  output  1  fmap_out valid.
REQ-012 sof  output  1  pulse with the first forwarded pixel of a frame.
REQ-013 eol  output  1  pulse with the last forwarded pixel of each row.
REQ-014 eof  output  1  pulse with the last forwarded pixel of a frame (coincides with eol).
REQ-015 busy  output  1  high while state is not IDLE.
REQ-016 err  output  1  sticky protocol error (present only with CROP_ROW_CHECK_EN).

Function
REQ-017 Column counter shall increment on each cycle with data_en_in=1, wrap to 0 after WIDTH-1; row counter shall increment on that wrap.
REQ-018 Counter widths shall be $clog2(WIDTH) and $clog2(DEPTH+2N); no other wrap points.
REQ-019 States: IDLE, TOP, PASS, BOT, DONE.
REQ-020 IDLE -> TOP when start_in=1 (N=0: IDLE -> PASS directly); counters cleared.
REQ-021 TOP: rows 0..N-1 discarded; -> PASS on wrap of row N-1.
REQ-022 PASS: rows N..N+DEPTH-1 forwarded; -> BOT on wrap of row N+DEPTH-1 (N=0: -> DONE).
REQ-023 BOT: rows N+DEPTH..DEPTH+2N-1 discarded; -> DONE on wrap of last row.
REQ-024 DONE: data_en_in ignored; -> IDLE when start_in=0.
REQ-025 start_in=0 in TOP/PASS/BOT shall abort to IDLE, clear counters, suppress eof; a forwarded beat on that same cycle is still output.
REQ-026 Latency: accepted pixel appears on fmap_out/data_en_out exactly 1 cycle after its input cycle; all outputs registered.
REQ-027 sof shall assert only for row N, column 0; eol for column WIDTH-1 in PASS; eof for row N+DEPTH-1, column WIDTH-1.
REQ-028 Pixel values shall pass unmodified; no back-pressure exists, input is never stalled.

Reset
REQ-029 On rst_n=0: state IDLE, counters 0, fmap_out 0, data_en_out/sof/eol/eof/busy 0, err 0.
REQ-030 Reset mid-frame shall discard the frame; the next start_in high after release begins a fresh frame.

Configuration
REQ-031 Macro CROP_ROW_CHECK_EN defined: err port exists and sets on data_en_in=1 in IDLE or DONE, or on abort per REQ-025; cleared only by reset.
REQ-032 Macro undefined: err port and checking logic absent; behaviour otherwise identical.

Verification (WIDTH=4, DEPTH=3, N=1, 2 blanking cycles per row)
REQ-033 Full padded frame, rows valued 10*row+col -> 12 beats out: 10..13, 20..23, 30..33, each 1 cycle after input; sof with 10, eol with 13/23/33, eof with 33.
REQ-034 Row 0 and row 4 fed non-zero values -> none appear; data_en_out=0 throughout TOP and BOT.
REQ-035 start_in dropped after pixel 21 -> output ends at 21, no eof, state IDLE next cycle; err=1 with macro.
REQ-036 rst_n asserted mid-PASS then second full frame -> outputs 0 during reset, second frame output exactly as REQ-033.
REQ-037 data_en_in pulsed in DONE with macro -> no output beat, err=1; without macro -> no output beat, no err port.
REQ-038 Back-to-back frames with start_in low for 1 cycle between -> both frames cropped correctly, sof per frame.
